// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM state encoding and 7-segment patterns for the display scan controller
package disp_pkg;
   typedef enum logic [1:0] {OFF, GAP, SHOW} state_t;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
      7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
   };
endpackage

// File: rtl/bcd7seg.sv
// bcd7seg: combinational BCD to 7-segment decoder, non-decimal codes show a dash
import disp_pkg::*;
module bcd7seg (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   // table lookup for 0-9, dash for 10-15
   always_comb seg = (bcd > 4'd9) ? SEG_DASH : SEG_TABLE[bcd];
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed 7-segment scan with blanking gaps and per-frame digit snapshot; DISP_SCAN_LZB_EN adds leading-zero blanking
import disp_pkg::*;
module disp_scan_ctrl #(
   parameter int DIGITS   = 2,
   parameter int SHOW_CYC = 50000,
   parameter int GAP_CYC  = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   digits,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_en,
   output logic                  frame_done
);
   localparam int CMAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   state_t                state, state_nx;
   logic [IW-1:0]         idx, idx_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic [4*DIGITS-1:0]   snap, snap_nx;
   logic [6:0]            seg_nx, dec_seg;
   logic [DIGITS-1:0]     dig_en_nx;
   logic                  fd_nx, blank;
   logic [3:0]            nib;
   // decoder source: digit 0 is taken from the input as it is being captured, others from the snapshot
   always_comb begin
      nib = digits[3:0];
      for (int i = 1; i < DIGITS; i++) if (idx == IW'(i)) nib = snap[4*i +: 4];
   end
`ifdef DISP_SCAN_LZB_EN
   // a non-zero digit blanks when it and all more-significant snapshot digits are zero
   always_comb begin
      blank = (idx != '0);
      for (int i = 1; i < DIGITS; i++) if (i >= int'(idx) && snap[4*i +: 4] != 4'd0) blank = 1'b0;
   end
`else
   // every digit shows its decoded value
   always_comb blank = 1'b0;
`endif
   bcd7seg u_dec (.bcd(nib), .seg(dec_seg));
   // next state, counters, snapshot and next registered outputs
   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      cnt_nx    = cnt + 1'b1;
      snap_nx   = snap;
      seg_nx    = seg;
      dig_en_nx = dig_en;
      fd_nx     = 1'b0;
      if (!en) begin
         state_nx  = OFF;
         idx_nx    = '0;
         cnt_nx    = '0;
         seg_nx    = SEG_BLANK;
         dig_en_nx = '0;
      end else begin
         case (state)
            OFF: begin
               state_nx = GAP;
               idx_nx   = '0;
               cnt_nx   = '0;
            end
            GAP: if (cnt == CW'(GAP_CYC - 1)) begin
               state_nx  = SHOW;
               cnt_nx    = '0;
               seg_nx    = blank ? SEG_BLANK : dec_seg;
               dig_en_nx = DIGITS'(1) << idx;
               fd_nx     = (idx == '0);
               snap_nx   = (idx == '0) ? digits : snap;
            end
            SHOW: if (cnt == CW'(SHOW_CYC - 1)) begin
               state_nx  = GAP;
               cnt_nx    = '0;
               idx_nx    = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
               seg_nx    = SEG_BLANK;
               dig_en_nx = '0;
            end
            default: begin
               state_nx  = OFF;
               cnt_nx    = '0;
               seg_nx    = SEG_BLANK;
               dig_en_nx = '0;
            end
         endcase
      end
   end
   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= OFF;
         idx        <= '0;
         cnt        <= '0;
         snap       <= '0;
         seg        <= SEG_BLANK;
         dig_en     <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         cnt        <= cnt_nx;
         snap       <= snap_nx;
         seg        <= seg_nx;
         dig_en     <= dig_en_nx;
         frame_done <= fd_nx;
      end
   end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for disp_scan_ctrl with DIGITS=2, SHOW_CYC=4, GAP_CYC=2
module tb_disp_scan_ctrl;
   localparam logic [6:0] S_BLK  = 7'b0000000;
   localparam logic [6:0] S_DASH = 7'b1000000;
   localparam logic [6:0] S0     = 7'b0111111;
   localparam logic [6:0] S2     = 7'b1011011;
   localparam logic [6:0] S3     = 7'b1001111;
   localparam logic [6:0] S5     = 7'b1101101;
   localparam logic [6:0] S7     = 7'b0000111;
`ifdef DISP_SCAN_LZB_EN
   localparam logic [6:0] S_LZ = S_BLK;
`else
   localparam logic [6:0] S_LZ = S0;
`endif
   typedef struct {
      logic [6:0] seg;
      logic [1:0] dig;
      logic       fd;
      int         n;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] digits = 8'h00;
   logic [6:0] seg;
   logic [1:0] dig_en;
   logic       frame_done;
   exp_t       q[$];
   int         tests = 0;
   int         fails = 0;
   int         n_cyc = 0;
   disp_scan_ctrl #(.DIGITS(2), .SHOW_CYC(4), .GAP_CYC(2)) dut (
      .clk(clk), .rst(rst), .en(en), .digits(digits),
      .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   // after each edge, record what the outputs must show in that cycle
   task automatic cyc(input logic [6:0] s, input logic [1:0] d, input logic f);
      exp_t e;
      @(posedge clk);
      #1;
      e.seg = s;
      e.dig = d;
      e.fd = f;
      e.n = n_cyc++;
      q.push_back(e);
   endtask
   task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [7:0] nd, input int n1);
      for (int i = 0; i < 2; i++) cyc(S_BLK, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(s0, 2'b01, i == 0);
         if (i == 0) digits = nd;
      end
      for (int i = 0; i < 2; i++) cyc(S_BLK, 2'b00, 1'b0);
      for (int i = 0; i < n1; i++) cyc(s1, 2'b10, 1'b0);
   endtask
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check($sformatf("seg@%0d", e.n), 32'(seg), 32'(e.seg));
         check($sformatf("dig_en@%0d", e.n), 32'(dig_en), 32'(e.dig));
         check($sformatf("frame_done@%0d", e.n), 32'(frame_done), 32'(e.fd));
      end
   end
   initial begin
      #3;
      check("rst_seg", 32'(seg), 0);
      check("rst_dig_en", 32'(dig_en), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      en = 1'b1;
      digits = 8'h37;
      frame(S7, S3, 8'h37, 4);
      frame(S7, S3, 8'h52, 4);
      frame(S2, S5, 8'hA3, 4);
      frame(S3, S_DASH, 8'h05, 4);
      frame(S5, S_LZ, 8'h05, 4);
      frame(S5, S_LZ, 8'h05, 2);
      en = 1'b0;
      cyc(S_BLK, 2'b00, 1'b0);
      en = 1'b1;
      frame(S5, S_LZ, 8'h05, 4);
      frame(S5, S_LZ, 8'h05, 2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_seg", 32'(seg), 0);
      check("async_dig_en", 32'(dig_en), 0);
      check("async_frame_done", 32'(frame_done), 0);
      cyc(S_BLK, 2'b00, 1'b0);
      rst = 1'b0;
      frame(S5, S_LZ, 8'h05, 4);
      @(negedge clk);
      #1;
      check("drain", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
